// File: rtl/uart_sys_ctrl.sv
`timescale 1ns/1ps
// uart_sys_ctrl: parses UART RX byte frames into RF write/read and ALU commands,
// drives the registered RF/ALU strobes and pushes response bytes into the TX FIFO.
//
// state    | meaning
// IDLE     | waiting for an opcode byte
// WR_ADDR  | RF write: waiting for address byte
// WR_DATA  | RF write: waiting for data byte
// RD_ADDR  | RF read: waiting for address byte
// RD_WAIT  | RF read issued, waiting for read data (timed)
// OPA      | ALU: waiting for operand A (written to RF[0])
// OPB      | ALU: waiting for operand B (written to RF[1])
// ALU_FUN  | ALU: waiting for function byte
// ALU_WAIT | ALU started, waiting for result (timed)
// SEND_RD  | pushing read data byte
// SEND_LO  | pushing result low byte
// SEND_HI  | pushing result high byte
// SEND_ERR | pushing timeout error byte
module uart_sys_ctrl #(
  parameter int WIDTH_REG = 8,
  parameter int ADDR_W    = 4,
  parameter int TMO_CYC   = 255
) (
  input  logic                 i_CLK,
  input  logic                 i_rst_n,
  input  logic [WIDTH_REG-1:0] i_RX_Data,
  input  logic                 i_RX_Vid,
  input  logic                 i_PAR_ERR,
  input  logic                 i_framing_ERR,
  output logic                 o_RF_WrEn,
  output logic                 o_RF_RdEn,
  output logic [ADDR_W-1:0]    o_RF_Addr,
  output logic [WIDTH_REG-1:0] o_RF_WrData,
  input  logic [WIDTH_REG-1:0] i_RF_RdData,
  input  logic                 i_RF_RdData_Vld,
  output logic                 o_ALU_En,
  output logic [3:0]           o_ALU_FUN,
  output logic                 o_CLK_GATE_EN,
  input  logic [15:0]          i_ALU_OUT,
  input  logic                 i_ALU_OUT_Vld,
  output logic [WIDTH_REG-1:0] o_FIFO_WrData,
  output logic                 o_FIFO_WrEn,
  input  logic                 i_FIFO_Full,
  output logic                 o_BUSY
);

  localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

  localparam logic [WIDTH_REG-1:0] OP_WR     = WIDTH_REG'(8'hAA);
  localparam logic [WIDTH_REG-1:0] OP_RD     = WIDTH_REG'(8'hBB);
  localparam logic [WIDTH_REG-1:0] OP_ALU_AB = WIDTH_REG'(8'hCC);
  localparam logic [WIDTH_REG-1:0] OP_ALU    = WIDTH_REG'(8'hDD);
  localparam logic [WIDTH_REG-1:0] ERR_BYTE  = WIDTH_REG'(8'hEE);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FUN, ALU_WAIT,
    SEND_RD, SEND_LO, SEND_HI, SEND_ERR
  } state_t;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr_q, addr_nxt;
  logic [CNT_W-1:0]     tmo_cnt, tmo_nxt;
  logic [WIDTH_REG-1:0] rd_q, rd_nxt;
  logic [15:0]          res_q, res_nxt;
  logic                 wr_en_nxt, rd_en_nxt, alu_en_nxt;
  logic [ADDR_W-1:0]    rf_addr_nxt;
  logic [WIDTH_REG-1:0] rf_wdata_nxt;
  logic [3:0]           alu_fun_nxt;
  logic                 fifo_we;
  logic [WIDTH_REG-1:0] fifo_data;
  logic                 rx_ok, rx_bad;

  assign rx_ok  = i_RX_Vid & ~(i_PAR_ERR | i_framing_ERR);
  assign rx_bad = i_RX_Vid &  (i_PAR_ERR | i_framing_ERR);

  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      tmo_cnt     <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      o_RF_WrEn   <= 1'b0;
      o_RF_RdEn   <= 1'b0;
      o_ALU_En    <= 1'b0;
      o_RF_Addr   <= '0;
      o_RF_WrData <= '0;
      o_ALU_FUN   <= '0;
    end else begin
      state       <= state_nxt;
      addr_q      <= addr_nxt;
      tmo_cnt     <= tmo_nxt;
      rd_q        <= rd_nxt;
      res_q       <= res_nxt;
      o_RF_WrEn   <= wr_en_nxt;
      o_RF_RdEn   <= rd_en_nxt;
      o_ALU_En    <= alu_en_nxt;
      o_RF_Addr   <= rf_addr_nxt;
      o_RF_WrData <= rf_wdata_nxt;
      o_ALU_FUN   <= alu_fun_nxt;
    end
  end

  // Timeout is a down-counter loaded on entry to a wait state; a valid seen on
  // the terminal-count cycle still wins over the timeout.
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    tmo_nxt      = '0;
    rd_nxt       = rd_q;
    res_nxt      = res_q;
    wr_en_nxt    = 1'b0;
    rd_en_nxt    = 1'b0;
    alu_en_nxt   = 1'b0;
    rf_addr_nxt  = o_RF_Addr;
    rf_wdata_nxt = o_RF_WrData;
    alu_fun_nxt  = o_ALU_FUN;
    fifo_we      = 1'b0;
    fifo_data    = '0;
    case (state)
      IDLE: begin
        if (rx_ok) begin
          case (i_RX_Data)
            OP_WR:     state_nxt = WR_ADDR;
            OP_RD:     state_nxt = RD_ADDR;
            OP_ALU_AB: state_nxt = OPA;
            OP_ALU:    state_nxt = ALU_FUN;
            default:   state_nxt = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (rx_bad) state_nxt = IDLE;
        else if (rx_ok) begin
          addr_nxt  = i_RX_Data[ADDR_W-1:0];
          state_nxt = WR_DATA;
        end
      end
      WR_DATA: begin
        if (rx_bad) state_nxt = IDLE;
        else if (rx_ok) begin
          wr_en_nxt    = 1'b1;
          rf_addr_nxt  = addr_q;
          rf_wdata_nxt = i_RX_Data;
          state_nxt    = IDLE;
        end
      end
      RD_ADDR: begin
        if (rx_bad) state_nxt = IDLE;
        else if (rx_ok) begin
          rd_en_nxt   = 1'b1;
          rf_addr_nxt = i_RX_Data[ADDR_W-1:0];
          tmo_nxt     = CNT_W'(TMO_CYC - 1);
          state_nxt   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (i_RF_RdData_Vld) begin
          rd_nxt    = i_RF_RdData;
          state_nxt = SEND_RD;
        end else if (tmo_cnt == '0) state_nxt = SEND_ERR;
        else tmo_nxt = tmo_cnt - CNT_W'(1);
      end
      OPA: begin
        if (rx_bad) state_nxt = IDLE;
        else if (rx_ok) begin
          wr_en_nxt    = 1'b1;
          rf_addr_nxt  = ADDR_W'(0);
          rf_wdata_nxt = i_RX_Data;
          state_nxt    = OPB;
        end
      end
      OPB: begin
        if (rx_bad) state_nxt = IDLE;
        else if (rx_ok) begin
          wr_en_nxt    = 1'b1;
          rf_addr_nxt  = ADDR_W'(1);
          rf_wdata_nxt = i_RX_Data;
          state_nxt    = ALU_FUN;
        end
      end
      ALU_FUN: begin
        if (rx_bad) state_nxt = IDLE;
        else if (rx_ok) begin
          alu_en_nxt  = 1'b1;
          alu_fun_nxt = i_RX_Data[3:0];
          tmo_nxt     = CNT_W'(TMO_CYC - 1);
          state_nxt   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (i_ALU_OUT_Vld) begin
          res_nxt   = i_ALU_OUT;
          state_nxt = SEND_LO;
        end else if (tmo_cnt == '0) state_nxt = SEND_ERR;
        else tmo_nxt = tmo_cnt - CNT_W'(1);
      end
      SEND_RD: begin
        fifo_data = rd_q;
        if (!i_FIFO_Full) begin
          fifo_we   = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND_LO: begin
        fifo_data = WIDTH_REG'(res_q[7:0]);
        if (!i_FIFO_Full) begin
          fifo_we   = 1'b1;
          state_nxt = SEND_HI;
        end
      end
      SEND_HI: begin
        fifo_data = WIDTH_REG'(res_q[15:8]);
        if (!i_FIFO_Full) begin
          fifo_we   = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND_ERR: begin
        fifo_data = ERR_BYTE;
        if (!i_FIFO_Full) begin
          fifo_we   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_FIFO_WrEn   = fifo_we;
  assign o_FIFO_WrData = fifo_data;
  assign o_BUSY        = (state != IDLE);
  assign o_CLK_GATE_EN = (state == ALU_FUN) || (state == ALU_WAIT);

endmodule

// File: tb/tb_uart_sys_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for uart_sys_ctrl: command-level model (expected strobe and
// response queues) plus directed literal cases and randomized command streams.
module tb_uart_sys_ctrl;
  localparam int WIDTH_REG = 8;
  localparam int ADDR_W    = 4;
  localparam int TMO_CYC   = 255;

  logic                 i_CLK = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [WIDTH_REG-1:0] i_RX_Data = '0;
  logic                 i_RX_Vid = 1'b0;
  logic                 i_PAR_ERR = 1'b0;
  logic                 i_framing_ERR = 1'b0;
  logic                 o_RF_WrEn, o_RF_RdEn;
  logic [ADDR_W-1:0]    o_RF_Addr;
  logic [WIDTH_REG-1:0] o_RF_WrData;
  logic [WIDTH_REG-1:0] i_RF_RdData = '0;
  logic                 i_RF_RdData_Vld = 1'b0;
  logic                 o_ALU_En;
  logic [3:0]           o_ALU_FUN;
  logic                 o_CLK_GATE_EN;
  logic [15:0]          i_ALU_OUT = '0;
  logic                 i_ALU_OUT_Vld = 1'b0;
  logic [WIDTH_REG-1:0] o_FIFO_WrData;
  logic                 o_FIFO_WrEn;
  logic                 i_FIFO_Full = 1'b0;
  logic                 o_BUSY;

  uart_sys_ctrl #(.WIDTH_REG(WIDTH_REG), .ADDR_W(ADDR_W), .TMO_CYC(TMO_CYC)) dut (
    .i_CLK(i_CLK), .i_rst_n(i_rst_n), .i_RX_Data(i_RX_Data), .i_RX_Vid(i_RX_Vid),
    .i_PAR_ERR(i_PAR_ERR), .i_framing_ERR(i_framing_ERR), .o_RF_WrEn(o_RF_WrEn),
    .o_RF_RdEn(o_RF_RdEn), .o_RF_Addr(o_RF_Addr), .o_RF_WrData(o_RF_WrData),
    .i_RF_RdData(i_RF_RdData), .i_RF_RdData_Vld(i_RF_RdData_Vld), .o_ALU_En(o_ALU_En),
    .o_ALU_FUN(o_ALU_FUN), .o_CLK_GATE_EN(o_CLK_GATE_EN), .i_ALU_OUT(i_ALU_OUT),
    .i_ALU_OUT_Vld(i_ALU_OUT_Vld), .o_FIFO_WrData(o_FIFO_WrData), .o_FIFO_WrEn(o_FIFO_WrEn),
    .i_FIFO_Full(i_FIFO_Full), .o_BUSY(o_BUSY)
  );

  always #5 i_CLK = ~i_CLK;

  int checks = 0;
  int errors = 0;
  bit full_rand = 1'b0;
  int cyc = 0;
  int last_rd_cyc = 0;
  int last_push_cyc = 0;
  int n_wr = 0;
  logic vid_ok_q = 1'b0;

  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [3:0]  exp_alu[$];
  logic [7:0]  exp_fifo[$];
  logic [7:0]  got_fifo[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] outvec();
    return {2'b00, o_RF_WrEn, o_RF_RdEn, o_RF_Addr, o_RF_WrData, o_ALU_En, o_ALU_FUN,
            o_CLK_GATE_EN, o_FIFO_WrData, o_FIFO_WrEn, o_BUSY};
  endfunction

  initial forever begin
    @(posedge i_CLK);
    cyc      <= cyc + 1;
    vid_ok_q <= i_RX_Vid & ~(i_PAR_ERR | i_framing_ERR);
  end

  // Compare process: every strobe must match the head of its expected queue.
  initial forever begin
    logic [11:0] e;
    bit have;
    @(negedge i_CLK);
    if (i_rst_n) begin
      if (o_RF_WrEn) begin
        n_wr++;
        chk("wr_latency", vid_ok_q, 1);
        have = exp_wr.size() != 0;
        chk("wr_expected", have, 1);
        if (have) begin
          e = exp_wr.pop_front();
          chk("wr_addr", o_RF_Addr, e[11:8]);
          chk("wr_data", o_RF_WrData, e[7:0]);
        end
      end
      if (o_RF_RdEn) begin
        last_rd_cyc = cyc;
        chk("rd_latency", vid_ok_q, 1);
        have = exp_rd.size() != 0;
        chk("rd_expected", have, 1);
        if (have) chk("rd_addr", o_RF_Addr, exp_rd.pop_front());
      end
      if (o_ALU_En) begin
        chk("alu_latency", vid_ok_q, 1);
        chk("alu_gate", o_CLK_GATE_EN, 1);
        have = exp_alu.size() != 0;
        chk("alu_expected", have, 1);
        if (have) chk("alu_fun", o_ALU_FUN, exp_alu.pop_front());
      end
      if (o_FIFO_WrEn) begin
        last_push_cyc = cyc;
        chk("push_while_full", i_FIFO_Full, 0);
        got_fifo.push_back(o_FIFO_WrData);
        have = exp_fifo.size() != 0;
        chk("push_expected", have, 1);
        if (have) chk("push_data", o_FIFO_WrData, exp_fifo.pop_front());
      end
      if (!o_BUSY) chk("gate_idle", o_CLK_GATE_EN, 0);
    end
  end

  task automatic tick();
    @(posedge i_CLK);
    #1;
    if (full_rand) i_FIFO_Full = ($urandom_range(0, 9) < 3);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit err);
    bit par;
    par = err && ($urandom_range(0, 1) == 1);
    i_RX_Vid = 1'b1;
    i_RX_Data = b;
    i_PAR_ERR = par;
    i_framing_ERR = err && !par;
    tick();
    i_RX_Vid = 1'b0;
    i_PAR_ERR = 1'b0;
    i_framing_ERR = 1'b0;
  endtask

  // Response arrives d cycles after the strobe cycle; a stray RX byte is dropped in mid-wait.
  task automatic respond(input bit is_alu, input int d, input logic [15:0] val);
    for (int j = 0; j < d; j++) begin
      if (d >= 2 && j == d / 2) begin
        i_RX_Vid = 1'b1;
        i_RX_Data = 8'($urandom);
      end
      tick();
      i_RX_Vid = 1'b0;
    end
    if (is_alu) begin
      i_ALU_OUT = val;
      i_ALU_OUT_Vld = 1'b1;
    end else begin
      i_RF_RdData = val[7:0];
      i_RF_RdData_Vld = 1'b1;
    end
    tick();
    i_ALU_OUT_Vld = 1'b0;
    i_RF_RdData_Vld = 1'b0;
  endtask

  // A response is accepted only within TMO_CYC wait cycles; otherwise a single 0xEE.
  task automatic expect_resp(input bit is_rd, input int d, input logic [15:0] val);
    if (d >= TMO_CYC) exp_fifo.push_back(8'hEE);
    else if (is_rd) exp_fifo.push_back(val[7:0]);
    else begin
      exp_fifo.push_back(val[7:0]);
      exp_fifo.push_back(val[15:8]);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (o_BUSY && n < TMO_CYC + 300) begin
      tick();
      n++;
    end
    chk({name, "_idle"}, o_BUSY, 0);
    repeat (2) tick();
    chk({name, "_wr_left"}, exp_wr.size(), 0);
    chk({name, "_rd_left"}, exp_rd.size(), 0);
    chk({name, "_alu_left"}, exp_alu.size(), 0);
    chk({name, "_push_left"}, exp_fifo.size(), 0);
    exp_wr.delete(); exp_rd.delete(); exp_alu.delete(); exp_fifo.delete();
  endtask

  task automatic run_cmd(input int kind, input int err_pos, input int d);
    logic [7:0] bytes[4];
    logic [7:0] a, b, f, j;
    logic [15:0] val;
    int nb;
    a = 8'($urandom); b = 8'($urandom); f = 8'($urandom); val = 16'($urandom);
    bytes[0] = 8'h00; bytes[1] = a; bytes[2] = b; bytes[3] = f;
    case (kind)
      0: begin
        nb = 3; bytes[0] = 8'hAA;
        if (err_pos < 0) exp_wr.push_back({a[3:0], b});
      end
      1: begin
        nb = 2; bytes[0] = 8'hBB;
        if (err_pos < 0) exp_rd.push_back(a[3:0]);
      end
      2: begin
        nb = 4; bytes[0] = 8'hCC;
        if (err_pos < 0 || err_pos >= 2) exp_wr.push_back({4'h0, a});
        if (err_pos < 0 || err_pos >= 3) exp_wr.push_back({4'h1, b});
        if (err_pos < 0) exp_alu.push_back(f[3:0]);
      end
      3: begin
        nb = 2; bytes[0] = 8'hDD; bytes[1] = f;
        if (err_pos < 0) exp_alu.push_back(f[3:0]);
      end
      default: begin
        nb = 1;
        do j = 8'($urandom); while (j inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
        bytes[0] = j;
      end
    endcase
    if (err_pos < 0 && kind >= 1 && kind <= 3) expect_resp(kind == 1, d, val);
    for (int i = 0; i < nb; i++) begin
      send_byte(bytes[i], i == err_pos);
      if (i == err_pos) break;
      if (i < nb - 1) repeat ($urandom_range(0, 2)) tick();
    end
    if (err_pos < 0 && kind >= 1 && kind <= 3) respond(kind != 1, d, val);
    wait_idle("rand");
  endtask

  initial begin
    int g0, w0, kind, nb, ep, r, d;
    repeat (2) tick();
    chk("reset_outputs", outvec(), 0);
    i_rst_n = 1'b1;
    tick();
    chk("post_reset_outputs", outvec(), 0);

    // AA 05 3C
    w0 = n_wr; g0 = got_fifo.size();
    exp_wr.push_back({4'h5, 8'h3C});
    send_byte(8'hAA, 0); send_byte(8'h05, 0); send_byte(8'h3C, 0);
    wait_idle("wr");
    chk("wr_count", n_wr - w0, 1);
    chk("wr_no_push", got_fifo.size() - g0, 0);

    // BB 05, read data 0x3C three cycles later
    exp_rd.push_back(4'h5); exp_fifo.push_back(8'h3C);
    send_byte(8'hBB, 0); send_byte(8'h05, 0);
    respond(0, 3, 16'h003C);
    wait_idle("rd");

    // CC 07 03 00, result 0x000A
    exp_wr.push_back({4'h0, 8'h07}); exp_wr.push_back({4'h1, 8'h03});
    exp_alu.push_back(4'h0); exp_fifo.push_back(8'h0A); exp_fifo.push_back(8'h00);
    send_byte(8'hCC, 0); send_byte(8'h07, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
    respond(1, 1, 16'h000A);
    wait_idle("alu_ab");

    // DD 01 with FIFO full held after the result; a stray byte while full is dropped
    g0 = got_fifo.size();
    exp_alu.push_back(4'h1); exp_fifo.push_back(8'h34); exp_fifo.push_back(8'h12);
    send_byte(8'hDD, 0); send_byte(8'h01, 0);
    i_FIFO_Full = 1'b1;
    respond(1, 2, 16'h1234);
    repeat (4) tick();
    send_byte(8'hAA, 0);
    repeat (4) tick();
    chk("full_no_push", got_fifo.size() - g0, 0);
    chk("full_busy", o_BUSY, 1);
    i_FIFO_Full = 1'b0;
    wait_idle("full");
    chk("full_push_count", got_fifo.size() - g0, 2);
    if (got_fifo.size() >= g0 + 2) begin
      chk("full_lo_first", got_fifo[g0], 8'h34);
      chk("full_hi_second", got_fifo[g0+1], 8'h12);
    end

    // BB 02, no read data in time -> 0xEE after TMO_CYC cycles
    exp_rd.push_back(4'h2); exp_fifo.push_back(8'hEE);
    send_byte(8'hBB, 0); send_byte(8'h02, 0);
    respond(0, TMO_CYC, 16'h0077);
    wait_idle("tmo");
    chk("tmo_delay", last_push_cyc - last_rd_cyc, TMO_CYC);

    // read data on the last wait cycle beats the timeout
    exp_rd.push_back(4'h9); exp_fifo.push_back(8'h5A);
    send_byte(8'hBB, 0); send_byte(8'h09, 0);
    respond(0, TMO_CYC - 1, 16'h005A);
    wait_idle("tmo_edge");
    chk("tmo_edge_delay", last_push_cyc - last_rd_cyc, TMO_CYC);

    // AA 05 then a data byte with a parity error
    w0 = n_wr;
    send_byte(8'hAA, 0); send_byte(8'h05, 0);
    i_RX_Vid = 1'b1; i_RX_Data = 8'h3C; i_PAR_ERR = 1'b1;
    tick();
    i_RX_Vid = 1'b0; i_PAR_ERR = 1'b0;
    wait_idle("par_err");
    chk("par_err_no_wr", n_wr - w0, 0);

    // reset while waiting for the ALU
    exp_alu.push_back(4'h3);
    send_byte(8'hDD, 0); send_byte(8'h03, 0);
    repeat (3) tick();
    chk("alu_wait_busy", o_BUSY, 1);
    chk("alu_wait_gate", o_CLK_GATE_EN, 1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", outvec(), 0);
    repeat (2) tick();
    i_rst_n = 1'b1;
    repeat (5) tick();
    chk("after_reset_outputs", outvec(), 0);
    exp_wr.push_back({4'hA, 8'h81});
    send_byte(8'hAA, 0); send_byte(8'h2A, 0); send_byte(8'h81, 0);
    wait_idle("recover");

    // randomized command stream with FIFO back-pressure
    full_rand = 1'b1;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      nb = (kind == 0) ? 3 : (kind == 2) ? 4 : (kind == 4) ? 1 : 2;
      ep = (kind != 4 && $urandom_range(0, 4) == 0) ? $urandom_range(0, nb - 1) : -1;
      r = $urandom_range(0, 19);
      if (r < 13) d = $urandom_range(0, 6);
      else if (r < 16) d = $urandom_range(7, 40);
      else if (r < 18) d = TMO_CYC - 1;
      else d = TMO_CYC;
      repeat ($urandom_range(0, 3)) tick();
      run_cmd(kind, ep, d);
    end
    full_rand = 1'b0;
    i_FIFO_Full = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
